// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with a two-flop input synchronizer and mid-bit sampling.
// Emits one byte plus a one-cycle valid strobe, or a one-cycle frame-error strobe.
// Optional even-parity bit between the data and stop bits when UART_RX_PARITY_EN is defined.
module uart_recv #(
    parameter int D = 234,  // clock cycles per bit (>= 8)
    parameter int L = 8     // bit-period counter width, must hold D-1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // Start bit is checked at its midpoint; every later bit is one full period on.
    localparam logic [L-1:0] HALF = L'(D / 2 - 1);
    localparam logic [L-1:0] LAST = L'(D - 1);

    logic         rx_meta_q, rx_s_q;
    state_t       state_q, state_d;
    logic [L-1:0] wait_q, wait_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   data_q, data_d;
    logic         valid_q, valid_d;
    logic         ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic         par_q, par_d;
    logic         perr_q, perr_d;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: frame sequencing and mid-bit sampling of rx_s.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (wait_q == HALF) begin
                    wait_d = '0;
                    cnt_d  = '0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    wait_d = wait_q + L'(1);
                end
            end
            S_DATA: begin
                if (wait_q == LAST) begin
                    wait_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    wait_d = wait_q + L'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (wait_q == LAST) begin
                    wait_d  = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    wait_d = wait_q + L'(1);
                end
            end
`endif
            S_STOP: begin
                if (wait_q == LAST) begin
                    wait_d = '0;
                    if (rx_s_q) begin
                        // Leave at mid-stop so a start edge right after the stop bit is seen.
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        data_d  = shift_q;
`endif
                    end else begin
                        // Bad stop wins over bad parity; park until the line recovers.
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    wait_d = wait_q + L'(1);
                end
            end
            S_BREAK: begin
                wait_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv (D=16): directed scenarios plus random frames
// scored against a frame-level model of the expected strobe per frame.
module tb_uart_recv;
    localparam int D = 16;
`ifdef UART_RX_PARITY_EN
    localparam int HAS_PAR = 1;
`else
    localparam int HAS_PAR = 0;
`endif
    // stop-bit sample lands near 9.5 (or 10.5) bit times after the start edge
    localparam int LAT_LO = (9 + HAS_PAR) * D + D / 2 - 2;
    localparam int LAT_HI = LAT_LO + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_busy;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] model_data;

    // event log: kind 0=valid 1=frame_err 2=parity_err 3=overlapping strobes
    int         ev_kind[$];
    logic [7:0] ev_data[$];
    int         ev_cyc[$];
    int         mon_k;

    uart_recv #(.D(D), .L(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx),
        .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err),
        .o_parity_err(o_parity_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (o_valid || o_frame_err || o_parity_err)) begin
            if (o_valid && !o_frame_err && !o_parity_err) mon_k = 0;
            else if (!o_valid && o_frame_err && !o_parity_err) mon_k = 1;
            else if (!o_valid && !o_frame_err && o_parity_err) mon_k = 2;
            else mon_k = 3;
            ev_kind.push_back(mon_k);
            ev_data.push_back(o_data);
            ev_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (D) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (HAS_PAR != 0) drive_bit((^b) ^ par_bad);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h want 00", o_data); end
        n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
        n_cmp++; if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", o_parity_err); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        rst = 1'b0;
        model_data = 8'h00;
        idle(4);
    endtask

    task automatic test_single();
        int t0;
        clear_log();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        model_data = 8'hA5;
        n_cmp++; if (ev_kind.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() >= 1) begin
            n_cmp++; if (ev_kind[0] !== 0) begin n_fail++; $display("FAIL single_kind: got %0d want 0", ev_kind[0]); end
            n_cmp++; if (ev_data[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %0h want a5", ev_data[0]); end
            n_cmp++;
            if (ev_cyc[0] - t0 < LAT_LO || ev_cyc[0] - t0 > LAT_HI) begin
                n_fail++; $display("FAIL single_latency: got %0d want %0d..%0d", ev_cyc[0] - t0, LAT_LO, LAT_HI);
            end
        end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_false_start();
        clear_log();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(10);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", o_busy); end
        idle(30);
        n_cmp++; if (ev_kind.size() !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", ev_kind.size()); end
        n_cmp++; if (o_data !== model_data) begin n_fail++; $display("FAIL glitch_data: got %0h want %0h", o_data, model_data); end
    endtask

    task automatic test_frame_err();
        clear_log();
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (320) @(negedge clk);
        idle(3 * D);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(2 * D);
        n_cmp++; if (ev_kind.size() !== 2) begin n_fail++; $display("FAIL ferr_count: got %0d want 2", ev_kind.size()); end
        if (ev_kind.size() >= 2) begin
            n_cmp++; if (ev_kind[0] !== 1) begin n_fail++; $display("FAIL ferr_kind: got %0d want 1", ev_kind[0]); end
            n_cmp++; if (ev_data[0] !== model_data) begin n_fail++; $display("FAIL ferr_data_held: got %0h want %0h", ev_data[0], model_data); end
            n_cmp++; if (ev_kind[1] !== 0) begin n_fail++; $display("FAIL ferr_next_kind: got %0d want 0", ev_kind[1]); end
            n_cmp++; if (ev_data[1] !== 8'h7E) begin n_fail++; $display("FAIL ferr_next_data: got %0h want 7e", ev_data[1]); end
        end
        model_data = 8'h7E;
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(20);
        n_cmp++; if (ev_kind.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", ev_kind.size()); end
        if (ev_kind.size() >= 2) begin
            n_cmp++; if (ev_kind[0] !== 0 || ev_data[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got k%0d %0h want k0 00", ev_kind[0], ev_data[0]); end
            n_cmp++; if (ev_kind[1] !== 0 || ev_data[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got k%0d %0h want k0 ff", ev_kind[1], ev_data[1]); end
            n_cmp++; if (ev_cyc[1] - ev_cyc[0] !== (10 + HAS_PAR) * D) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", ev_cyc[1] - ev_cyc[0], (10 + HAS_PAR) * D); end
        end
        model_data = 8'hFF;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h55;
        clear_log();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (D / 2) @(negedge clk);
        // transmitter side is reset too, so the line returns to idle
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 8'h00;
        n_cmp++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %0h want 00", o_data); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
        n_cmp++; if ({o_valid, o_frame_err, o_parity_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_strobes: got %b want 000", {o_valid, o_frame_err, o_parity_err}); end
        idle(12 * D);
        n_cmp++; if (ev_kind.size() !== 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d want 0", ev_kind.size()); end
        clear_log();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2 * D);
        n_cmp++; if (ev_kind.size() !== 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d want 1", ev_kind.size()); end
        if (ev_kind.size() >= 1) begin
            n_cmp++; if (ev_kind[0] !== 0 || ev_data[0] !== 8'h81) begin n_fail++; $display("FAIL rstmid_next: got k%0d %0h want k0 81", ev_kind[0], ev_data[0]); end
        end
        model_data = 8'h81;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_log();
        send_frame(8'h03, 1'b1, 1'b0);
        idle(D);
        send_frame(8'h03, 1'b1, 1'b1);
        idle(2 * D);
        n_cmp++; if (ev_kind.size() !== 2) begin n_fail++; $display("FAIL par_count: got %0d want 2", ev_kind.size()); end
        if (ev_kind.size() >= 2) begin
            n_cmp++; if (ev_kind[0] !== 0 || ev_data[0] !== 8'h03) begin n_fail++; $display("FAIL par_good: got k%0d %0h want k0 03", ev_kind[0], ev_data[0]); end
            n_cmp++; if (ev_kind[1] !== 2) begin n_fail++; $display("FAIL par_bad_kind: got %0d want 2", ev_kind[1]); end
        end
        model_data = 8'h03;
        n_cmp++; if (o_data !== model_data) begin n_fail++; $display("FAIL par_data_held: got %0h want %0h", o_data, model_data); end
    endtask
`endif

    task automatic test_random();
        int         exp_kind[$];
        logic [7:0] exp_data[$];
        int         start_cyc[$];
        logic [7:0] b;
        logic       stop_bad, par_bad, prev_bad;
        int         gap;
        prev_bad = 1'b0;
        clear_log();
        for (int f = 0; f < 24; f++) begin
            b = 8'($urandom);
            stop_bad = ($urandom_range(0, 7) == 0);
            par_bad = (HAS_PAR != 0) && ($urandom_range(0, 3) == 0);
            gap = prev_bad ? D + $urandom_range(0, D) : $urandom_range(0, 2 * D);
            idle(gap);
            start_cyc.push_back(cyc);
            send_frame(b, !stop_bad, par_bad);
            if (stop_bad) begin
                exp_kind.push_back(1); exp_data.push_back(model_data);
            end else if (par_bad) begin
                exp_kind.push_back(2); exp_data.push_back(model_data);
            end else begin
                model_data = b;
                exp_kind.push_back(0); exp_data.push_back(b);
            end
            prev_bad = stop_bad;
        end
        idle(2 * D);
        n_cmp++; if (ev_kind.size() !== exp_kind.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", ev_kind.size(), exp_kind.size()); end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            n_cmp++;
            if (ev_kind[i] !== exp_kind[i] || ev_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL rand_frame%0d: got k%0d %0h want k%0d %0h", i, ev_kind[i], ev_data[i], exp_kind[i], exp_data[i]);
            end
            n_cmp++;
            if (ev_cyc[i] - start_cyc[i] < LAT_LO || ev_cyc[i] - start_cyc[i] > LAT_HI) begin
                n_fail++; $display("FAIL rand_latency%0d: got %0d want %0d..%0d", i, ev_cyc[i] - start_cyc[i], LAT_LO, LAT_HI);
            end
        end
        n_cmp++; if (o_data !== model_data) begin n_fail++; $display("FAIL rand_final_data: got %0h want %0h", o_data, model_data); end
    endtask

    initial begin
        model_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver: 8N1 serial line in, one byte plus a one-cycle valid strobe out.
- Consumes the serial stream produced by the `send` transmitter at the same bit rate.
- Feeds the byte-level logic downstream (LED/command decode).
- Uses the same clocks-per-bit convention as the transmitter: 27 MHz clock, 115200 baud.

Parameters:
- D, 234, clock cycles per bit, round(27 MHz / 115200); minimum legal value 8.
- L, 8, width of the bit-period counter; must hold D-1.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idles high.
- o_data  output  8  last correctly received byte; holds until the next good frame.
- o_valid  output  1  one-cycle pulse; o_data is new this cycle.
- o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
- o_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: single clock, i_clk; reset is synchronous and active-high on i_rst. All state is cleared only on a rising i_clk edge while i_rst=1. Reset values:
  - o_data=8'h00; o_valid=0; o_frame_err=0; o_parity_err=0; o_busy=0.
  - State=IDLE; bit counter=0; wait counter=0.
  - Both synchronizer flops=1.
- Input synchronizer: i_rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Sampling: r_wait counts 0..D-1. Samples are taken at mid-bit.
- States and transitions:
  - IDLE: rx_s==0 -> START, r_wait=0.
  - START: at r_wait==D/2-1 (integer divide), sample rx_s.
    - rx_s==0 -> DATA, r_wait=0, r_cnt=0.
    - rx_s==1 -> false start; back to IDLE with no output pulse.
  - DATA: at each r_wait==D-1, shift r_shift <= {rx_s, r_shift[7:1]} (LSB first) and reset r_wait=0.
    - After the 8th bit (r_cnt==7): go to STOP, or to PARITY if the feature is enabled.
  - STOP: at r_wait==D-1, sample rx_s.
    - rx_s==1: o_data<=r_shift, o_valid=1 for one cycle; go to IDLE.
    - rx_s==0: o_frame_err=1 for one cycle, o_data unchanged; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Prevents a held-low line from producing repeated errors.
- Latency: o_valid rises on the edge that samples the stop bit. That is about 9.5·D + 2 cycles after the i_rx falling edge.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge arriving directly after the stop bit is caught.
- Outputs:
  - o_valid, o_frame_err and o_parity_err are registered and mutually exclusive.
  - o_busy is derived from the state.
- Reset mid-frame: the frame is abandoned immediately and no pulse is emitted. The next full frame is received normally.
- i_rx glitch shorter than D/2 while in IDLE: rejected as a false start.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; one extra bit, sampled at r_wait==D-1.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: o_parity_err pulses for one cycle in place of o_valid, at stop-sample time, and o_data is not updated.
  - If parity and stop are both bad, o_frame_err takes priority.
- Undefined:
  - No PARITY state; 8N1 framing only.
  - o_parity_err is tied to 0.

Test Plan:
- D=16: drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> o_data=8'hA5, o_valid high for exactly 1 cycle, about 154 cycles after the edge; o_busy low afterwards.
- D=16: pulse i_rx low for 4 cycles, then high -> no o_valid, no o_frame_err; o_busy returns to 0 within 10 cycles.
- D=16: after 0xA5, send frame 0x3C with stop=0, then hold the line low for 320 cycles, then high, then send 0x7E -> exactly one o_frame_err pulse; o_data stays 0xA5; then o_data=0x7E with one o_valid.
- D=16: send 0x00 and 0xFF back-to-back with no idle gap -> two o_valid pulses 160 cycles apart; o_data=0x00, then 0xFF.
- D=16: assert i_rst for one cycle during bit 4 of 0x55 -> all outputs take reset values and no pulse is emitted; the following frame 0x81 gives o_data=0x81 with o_valid.
- UART_RX_PARITY_EN, D=16: 0x03 with parity 0 -> o_valid; 0x03 with parity 1 -> o_parity_err only, o_data unchanged.
